// File: rtl/sd_pkg.sv
// Shared SD-bus constants and the response-receiver state encoding.
package sd_pkg;

  localparam int          SD_RESP_LEN  = 48;
  localparam logic [6:0]  SD_CRC7_POLY = 7'h09;
  localparam int          SD_NCR_MAX   = 64;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_WAIT  = 2'd1,
    RX_SHIFT = 2'd2,
    RX_DONE  = 2'd3
  } sd_rx_state_t;

endpackage

// File: rtl/crc7_serial.sv
// Bit-serial CRC7 (x^7 + x^3 + 1), MSB-first, zero initial value.
module crc7_serial
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_i,
  output logic [6:0] crc_o
);

  logic fb;
  assign fb = bit_i ^ crc_o[6];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_o <= '0;
    end else if (clr) begin
      crc_o <= '0;
    end else if (en) begin
      crc_o <= {crc_o[5:0], 1'b0} ^ (fb ? SD_CRC7_POLY : 7'h00);
    end
  end

endmodule

// File: rtl/sd_resp_rx.sv
// SD 48-bit command-response receiver: start-bit hunt, deserialise, on-the-fly CRC7.
//   state    | meaning
//   RX_IDLE  | waiting for start_i; results held
//   RX_WAIT  | hunting for the start bit, NCR timeout running
//   RX_SHIFT | shifting in bits 46..0
//   RX_DONE  | one-cycle result/done_o window
module sd_resp_rx
  import sd_pkg::*;
#(
  parameter int NCR_MAX = SD_NCR_MAX
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        smp_en_i,
  input  logic        cmd_i,
  input  logic        start_i,
  input  logic        crc_chk_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [5:0]  index_o,
  output logic [31:0] arg_o,
  output logic        crc_err_o,
  output logic        frame_err_o,
  output logic        timeout_o
);

  localparam int         TW       = $clog2(NCR_MAX + 1);
  localparam logic [5:0] LAST_BIT = 6'(SD_RESP_LEN - 1);
  localparam logic [5:0] CRC_LAST = 6'(SD_RESP_LEN - 9);

  sd_rx_state_t   state;
  logic [45:0]    shreg;
  logic [5:0]     bit_cnt;
  logic [TW-1:0]  tmo_cnt;
  logic           crc_chk_l;
  logic           crc_clr;
  logic           crc_en;
  logic [6:0]     crc_calc;
  logic [46:0]    frame;

  // The end bit is never stored: it is taken straight from cmd_i on the last strobe.
  assign frame   = {shreg, cmd_i};
  assign crc_clr = (state == RX_IDLE) && start_i;
  assign crc_en  = smp_en_i && (((state == RX_WAIT) && !cmd_i) ||
                                ((state == RX_SHIFT) && (bit_cnt <= CRC_LAST)));

  crc7_serial u_crc (
    .clk   (clk_i),
    .rst   (rst_i),
    .clr   (crc_clr),
    .en    (crc_en),
    .bit_i (cmd_i),
    .crc_o (crc_calc)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= RX_IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      tmo_cnt     <= '0;
      crc_chk_l   <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      index_o     <= '0;
      arg_o       <= '0;
      crc_err_o   <= 1'b0;
      frame_err_o <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      case (state)
        RX_IDLE: begin
          if (start_i) begin
            busy_o      <= 1'b1;
            index_o     <= '0;
            arg_o       <= '0;
            crc_err_o   <= 1'b0;
            frame_err_o <= 1'b0;
            timeout_o   <= 1'b0;
            crc_chk_l   <= crc_chk_i;
            tmo_cnt     <= TW'(NCR_MAX - 1);
            bit_cnt     <= '0;
            state       <= RX_WAIT;
          end
        end
        RX_WAIT: begin
          if (smp_en_i) begin
            if (!cmd_i) begin
              bit_cnt <= 6'd1;
              state   <= RX_SHIFT;
            end else if (tmo_cnt == '0) begin
              timeout_o <= 1'b1;
              done_o    <= 1'b1;
              state     <= RX_DONE;
            end else begin
              tmo_cnt <= tmo_cnt - 1'b1;
            end
          end
        end
        RX_SHIFT: begin
          if (smp_en_i) begin
            shreg   <= {shreg[44:0], cmd_i};
            bit_cnt <= bit_cnt + 6'd1;
            if (bit_cnt == LAST_BIT) begin
              index_o     <= frame[45:40];
              arg_o       <= frame[39:8];
              crc_err_o   <= crc_chk_l && (frame[7:1] != crc_calc);
              frame_err_o <= frame[46] || !frame[0];
              done_o      <= 1'b1;
              state       <= RX_DONE;
            end
          end
        end
        RX_DONE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sd_resp_rx.md
# sd_resp_rx

Bit-serial receiver for SD-bus command responses, 48-bit format (R1/R1b/R3/R6/R7). Hunts for the start bit on the CMD line after the host command has been sent, deserialises the frame, and checks its CRC7 on the fly. It reports index, argument and error status to the command controller. It is the receive-side counterpart of the host's command CRC7 generator: same polynomial x^7+x^3+1, same 40-bit coverage.

## Interface

Parameters:
- `NCR_MAX`, default 64: number of sample strobes to wait for a start bit before declaring a timeout.

Ports:
- `clk_i`  in  1  system clock; single clock domain.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `smp_en_i`  in  1  sample strobe, one `clk_i` cycle per SD clock rising edge; `cmd_i` is sampled only when high.
- `cmd_i`  in  1  CMD line, already synchronised.
- `start_i`  in  1  arm the receiver; honoured only in IDLE.
- `crc_chk_i`  in  1  captured with `start_i`; 0 disables the CRC check (R3).
- `busy_o`  out  1  high in WAIT, SHIFT and DONE.
- `done_o`  out  1  one-cycle completion pulse.
- `index_o`  out  6  response bits [45:40].
- `arg_o`  out  32  response bits [39:8].
- `crc_err_o`  out  1  received CRC7 does not match the computed CRC7.
- `frame_err_o`  out  1  transmission bit not 0, or end bit not 1.
- `timeout_o`  out  1  no start bit within `NCR_MAX` strobes.

## Operation

Frame layout, MSB first:
- bit 47 start = 0
- bit 46 transmission = 0
- bits [45:40] index
- bits [39:8] argument
- bits [7:1] CRC7
- bit 0 end = 1

CRC7:
- Covers bits 47..8 (40 bits). Initial value 0.
- Per sampled bit b: fb = b ^ crc[6]; crc <= {crc[5:3], crc[2]^fb, crc[1:0], fb}.

State machine:
- IDLE: on `start_i`, clear all status outputs, latch `crc_chk_i`, clear the CRC and the strobe counter, then go to WAIT.
- WAIT: on each strobe, if `cmd_i`=0, the start bit is consumed (CRC fed 0, bit counter = 1) and the FSM goes to SHIFT. Otherwise the timeout counter increments. On the `NCR_MAX`-th strobe with `cmd_i`=1, set `timeout_o`=1 and go to DONE.
- SHIFT: on each strobe, shift `cmd_i` into a 47-bit register and increment the 6-bit bit counter. The CRC is fed while counter ≤ 39. On the strobe sampling bit 0 (counter = 47), go to DONE.
- DONE: for one cycle, drive `index_o`/`arg_o` from the shift register. `crc_err_o` = `crc_chk_l` & (rx CRC ≠ computed CRC). `frame_err_o` = (bit46 ≠ 0) | (end bit ≠ 1). Assert `done_o`, then go to IDLE.

Boundary conditions:
- `start_i` outside IDLE is ignored.
- `smp_en_i` is ignored in DONE.
- Outputs hold their values until the next accepted `start_i`.
- On timeout, `index_o`/`arg_o` are 0 and `crc_err_o`/`frame_err_o` are 0.
- Asserting `rst_i` mid-frame returns immediately to IDLE with all outputs 0. No partial `done_o` is produced.
- `start_i` and `smp_en_i` in the same cycle: the strobe is not sampled, and WAIT begins with the next strobe.

## Timing

- Reset values: `busy_o`, `done_o`, `index_o`, `arg_o`, `crc_err_o`, `frame_err_o` and `timeout_o` are all 0.
- `busy_o` rises the cycle after `start_i` is accepted.
- `done_o` goes high the `clk_i` cycle after the strobe that samples the end bit (or the timeout strobe). It lasts exactly one cycle, and `busy_o` falls with it.
- All outputs are registered, and result outputs are valid in the same cycle as `done_o`.
- Throughput: a new `start_i` is accepted the cycle after `done_o`.

## Structure

- Shared package `sd_pkg` holds:
  - `SD_RESP_LEN` = 48
  - `SD_CRC7_POLY` = 7'h09
  - `SD_NCR_MAX` = 64
  - state encoding `sd_rx_state_t` (IDLE, WAIT, SHIFT, DONE)
- One sub-module, `crc7_serial`: a bit-serial CRC7 engine with `clr`, `en`, `bit_i` and `crc_o`. It is reusable by the data-line and command-transmit paths.

## Test plan

- Spec R1 example for CMD17: bytes 11 00 00 09 00, then CRC 7'h33 and end bit 1, with `crc_chk_i`=1 and a start bit after 5 idle strobes. Required: `index_o`=6'h11, `arg_o`=32'h0000_0900, and no error flags.
- Same frame with argument bit 8 flipped. Required: `crc_err_o`=1, `frame_err_o`=0, `arg_o`=32'h0000_0800.
- R3 frame 3F FF FF FF FF, CRC field 7'h7F, end bit 1, with `crc_chk_i`=0. Required: `index_o`=6'h3F, `arg_o`=32'hFFFF_FFFF, `crc_err_o`=0.
- `cmd_i` held at 1 for 64 strobes. Required: `timeout_o`=1 and `done_o` the cycle after the 64th strobe. A start bit arriving on the 63rd strobe completes normally.
- CMD17 frame with end bit 0, and separately with transmission bit 1. Required: `frame_err_o`=1 in each case.
- `rst_i` asserted at bit 20 of a frame, then a new `start_i` and a clean frame. Required: no `done_o` from the aborted frame, and the second frame decodes correctly.
- Strobes spaced irregularly (1–4 `clk_i` cycles apart) throughout any of the above frames. Required: identical results.
